// File: rtl/alu_div.sv
// Restoring divider: one quotient bit per clock; done DATA_WIDTH+1 edges after accept (next edge for divide-by-zero).
// No backpressure: start is taken only in IDLE/DONE and ignored while busy; results hold until the next completion.
module alu_div #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
  logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;

  logic                  accept;
  logic                  a_neg, b_neg;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic [DATA_WIDTH:0]   shifted, trial;

  assign accept  = start && (state_q == IDLE || state_q == DONE);
  assign a_neg   = is_signed & dividend[DATA_WIDTH-1];
  assign b_neg   = is_signed & divisor[DATA_WIDTH-1];
  assign a_mag   = a_neg ? -dividend : dividend;
  assign b_mag   = b_neg ? -divisor : divisor;
  // quo_q holds the unconsumed dividend bits at the top and grows quotient bits at the bottom
  assign shifted = {rem_q[DATA_WIDTH-1:0], quo_q[DATA_WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '0;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d   = CALC;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = a_mag;
            dvs_d     = b_mag;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end
      CALC: begin
        // a set top bit means the trial subtraction borrowed: restore
        rem_d = trial[DATA_WIDTH] ? shifted : trial;
        quo_d = {quo_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        quotient_d  = neg_quo_q ? -quo_q : quo_q;
        remainder_d = neg_rem_q ? -rem_q[DATA_WIDTH-1:0] : rem_q[DATA_WIDTH-1:0];
        dbz_d       = 1'b0;
        state_d     = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_div.sv
// Directed bench for alu_div: hand-computed quotients/remainders, latency, reset and back-to-back behaviour.
module tb_alu_div;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_div #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at the sample point just after the accepting edge; returns edges until done.
  task automatic wait_done(input bit scramble, output int edges, output int busy_cnt, output int overlap);
    edges = 0;
    busy_cnt = 0;
    overlap = 0;
    while (!done && edges < 200) begin
      if (busy) busy_cnt++;
      if (scramble) begin
        dividend  = 64'(edges * 37 + 5);
        divisor   = '0;
        is_signed = edges[0];
      end
      step();
      edges++;
    end
    if (busy && done) overlap++;
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_q, input logic [W-1:0] exp_r, input logic exp_z,
                        input int exp_lat);
    int e, bc, ov;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    step();
    start = 1'b0;
    wait_done(1'b0, e, bc, ov);
    chk({tag, " latency"}, 64'(e), 64'(exp_lat));
    chk({tag, " busy cycles"}, 64'(bc), 64'(exp_lat));
    chk({tag, " quotient"}, quotient, exp_q);
    chk({tag, " remainder"}, remainder, exp_r);
    chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(exp_z));
    chk({tag, " busy&done overlap"}, 64'(ov), 64'd0);
    step();
    chk({tag, " done single pulse"}, 64'(done), 64'd0);
    chk({tag, " quotient hold"}, quotient, exp_q);
    chk({tag, " remainder hold"}, remainder, exp_r);
  endtask

  initial begin
    int e, bc, ov;

    // start asserted during reset must be ignored
    rst_n = 1'b0;
    start = 1'b1;
    dividend = 64'd5;
    divisor = 64'd1;
    step();
    step();
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset quotient", quotient, 64'd0);
    chk("reset remainder", remainder, 64'd0);
    chk("reset div_by_zero", 64'(div_by_zero), 64'd0);
    start = 1'b0;
    rst_n = 1'b1;

    run_op("udiv 100/7", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65);
    run_op("sdiv -100/7", 1'b1, -64'd100, 64'd7, -64'd14, -64'd2, 1'b0, 65);
    run_op("sdiv 100/-7", 1'b1, 64'd100, -64'd7, -64'd14, 64'd2, 1'b0, 65);
    run_op("sdiv -100/-7", 1'b1, -64'd100, -64'd7, 64'd14, -64'd2, 1'b0, 65);
    run_op("udiv max/1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 65);
    run_op("sdiv min/-1", 1'b1, 64'h8000_0000_0000_0000, -64'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 65);
    run_op("udiv 55/0", 1'b0, 64'd55, 64'd0, 64'd0, 64'd55, 1'b1, 0);
    run_op("sdiv 55/0", 1'b1, 64'd55, 64'd0, 64'd0, 64'd55, 1'b1, 0);

    // reset while the counter sits at iteration 30
    is_signed = 1'b0;
    dividend = 64'd1000;
    divisor = 64'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (30) step();
    chk("mid-calc busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid-calc reset busy", 64'(busy), 64'd0);
    chk("mid-calc reset done", 64'(done), 64'd0);
    chk("mid-calc reset quotient", quotient, 64'd0);
    chk("mid-calc reset remainder", remainder, 64'd0);
    chk("mid-calc reset div_by_zero", 64'(div_by_zero), 64'd0);
    step();
    chk("post-reset idle", 64'(busy), 64'd0);
    run_op("udiv 9/3", 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 1'b0, 65);

    // start held high: operands churn while busy, second op taken in the DONE cycle
    is_signed = 1'b0;
    dividend = 64'd200;
    divisor = 64'd9;
    start = 1'b1;
    step();
    wait_done(1'b1, e, bc, ov);
    chk("b2b A latency", 64'(e), 64'd65);
    chk("b2b A quotient", quotient, 64'd22);
    chk("b2b A remainder", remainder, 64'd2);
    chk("b2b A overlap", 64'(ov), 64'd0);
    is_signed = 1'b1;
    dividend = -64'd1000;
    divisor = 64'd7;
    step();
    chk("b2b B accepted busy", 64'(busy), 64'd1);
    chk("b2b B accepted done", 64'(done), 64'd0);
    chk("b2b A quotient hold", quotient, 64'd22);
    wait_done(1'b1, e, bc, ov);
    chk("b2b B latency", 64'(e), 64'd65);
    chk("b2b B busy cycles", 64'(bc), 64'd65);
    chk("b2b B quotient", quotient, -64'd142);
    chk("b2b B remainder", remainder, -64'd6);
    chk("b2b B div_by_zero", 64'(div_by_zero), 64'd0);
    start = 1'b0;
    step();
    chk("b2b end done", 64'(done), 64'd0);
    chk("b2b end busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_div.md
ALU_DIV -- requirements
Module: alu_div

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 64, setting the operand and result width.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The module SHALL have port start, input, 1 bit: request a divide; sampled only when accepted (REQ-011).
REQ-005 The module SHALL have port is_signed, input, 1 bit: 1 = SDIV (two's complement), 0 = UDIV; sampled with start.
REQ-006 The module SHALL have port dividend, input, DATA_WIDTH bits: numerator, sampled with start.
REQ-007 The module SHALL have port divisor, input, DATA_WIDTH bits: denominator, sampled with start.
REQ-008 The module SHALL have port busy, output, 1 bit: high while a divide is in progress (states CALC, FIX).
REQ-009 The module SHALL have port done, output, 1 bit: single-cycle pulse, results valid.
REQ-010 The module SHALL have ports quotient and remainder, outputs, DATA_WIDTH bits each, plus div_by_zero, output, 1 bit; all registered.

Function
REQ-011 The FSM SHALL use states IDLE, CALC, FIX, DONE; start is accepted only in IDLE or DONE; start in CALC/FIX is ignored with no effect.
REQ-012 On accepted start with divisor != 0, the block SHALL latch operands and sign info and enter CALC with iteration counter 0.
REQ-013 For is_signed=1, the block SHALL latch magnitudes (two's complement negation of negative operands) and record sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend).
REQ-014 CALC SHALL perform one restoring shift-subtract step per clock, MSB first, exactly DATA_WIDTH steps, then go to FIX.
REQ-015 The partial remainder SHALL be DATA_WIDTH+1 bits wide so no borrow is lost on the trial subtraction.
REQ-016 FIX SHALL negate quotient if sign_q and remainder if sign_r (signed only), write quotient/remainder, clear div_by_zero, and go to DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE, or CALC if start is accepted there.
REQ-018 Latency: done SHALL be high in the cycle following the (DATA_WIDTH+1)th rising edge after the start-sampling edge (65 edges for DATA_WIDTH=64).
REQ-019 Quotient SHALL truncate toward zero; remainder SHALL take the dividend's sign; dividend = quotient*divisor + remainder (mod 2^DATA_WIDTH).
REQ-020 Divisor == 0: accepted start SHALL go directly IDLE/DONE -> DONE with quotient=0, remainder=dividend, div_by_zero=1; done high in the cycle after the start edge.
REQ-021 Signed overflow (dividend = most negative, divisor = -1) SHALL yield quotient = most negative, remainder = 0, div_by_zero = 0.
REQ-022 quotient, remainder and div_by_zero SHALL hold their values from done until overwritten by the next completing operation.
REQ-023 busy SHALL be 1 exactly in CALC and FIX; busy and done SHALL never both be 1.

Reset
REQ-024 When rst_n=0 at a rising edge, the FSM SHALL go to IDLE and busy, done, div_by_zero, quotient, remainder SHALL all become 0, including mid-CALC.
REQ-025 start SHALL be ignored in any cycle where rst_n=0; the first start is accepted on the first edge with rst_n=1.

Verification
REQ-026 UDIV 100 / 7, start for 1 cycle -> done exactly per REQ-018, quotient=14, remainder=2, div_by_zero=0, busy high for 65 cycles.
REQ-027 SDIV -100 / 7 -> quotient=-14, remainder=-2; SDIV 100 / -7 -> quotient=-14, remainder=2; SDIV -100 / -7 -> quotient=14, remainder=-2.
REQ-028 UDIV 0xFFFF_FFFF_FFFF_FFFF / 1 -> quotient=all ones, remainder=0; SDIV 0x8000_0000_0000_0000 / -1 -> quotient=0x8000_0000_0000_0000, remainder=0.
REQ-029 Divide 55 / 0 (both modes) -> done one cycle after start, quotient=0, remainder=55, div_by_zero=1, busy never high.
REQ-030 rst_n=0 at CALC iteration 30 -> next cycle all outputs 0, state IDLE; a new 9 / 3 then completes normally with quotient=3, remainder=0.
REQ-031 start held high continuously with changing operands -> start ignored while busy; back-to-back op accepted in the DONE cycle; each result matches the operands sampled at its acceptance edge.
